// File: rtl/iob_arb_pkg.sv
// -----------------------------------------------------------------------------
// iob_arb_pkg
// Shared definitions for the C16M-domain I/O-bus arbiter: the arbiter state
// encoding, parameter defaults and legal parameter ranges, and datapath widths.
// No ports; imported by iob_arb and iob_arb_ref_debt.
// -----------------------------------------------------------------------------
package iob_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    REF     = 2'd2,
    RECOVER = 2'd3
  } state_e;

  // Parameter defaults
  localparam int REF_CYC_DEF  = 8;
  localparam int REC_CYC_DEF  = 2;
  localparam int MAX_DEBT_DEF = 3;

  // Legal parameter ranges
  localparam int REF_CYC_MIN  = 2;
  localparam int REF_CYC_MAX  = 15;
  localparam int REC_CYC_MIN  = 1;
  localparam int REC_CYC_MAX  = 3;
  localparam int MAX_DEBT_MIN = 1;
  localparam int MAX_DEBT_MAX = 3;

  // Widths
  localparam int CNT_W  = 4;
  localparam int DEBT_W = 2;

endpackage

// File: rtl/iob_arb_ref_debt.sv
// -----------------------------------------------------------------------------
// iob_arb_ref_debt
// Tracks how many refreshes are owed. RefReq passes through one sync stage and
// a second delay flop; a 0->1 transition adds one to the debt, a completed
// refresh removes one. The count saturates at MAX_DEBT and a refresh edge that
// arrives at saturation (without a simultaneous completion) sets a sticky
// overrun flag that only reset clears.
//
// Ports:
//   clk_i       in   C16M clock
//   rst_ni      in   asynchronous active-low reset
//   ref_req_i   in   refresh-due level from the refresh timer
//   ref_done_i  in   high during the last cycle of a refresh
//   debt_o      out  owed-refresh count (registered)
//   overrun_o   out  sticky overrun flag (registered)
// -----------------------------------------------------------------------------
module iob_arb_ref_debt
  import iob_arb_pkg::*;
#(
  parameter int MAX_DEBT = MAX_DEBT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ref_req_i,
  input  logic              ref_done_i,
  output logic [DEBT_W-1:0] debt_o,
  output logic              overrun_o
);

  localparam logic [DEBT_W-1:0] DEBT_SAT = DEBT_W'(MAX_DEBT);

  logic              req_sync_q;
  logic              req_dly_q;
  logic              rise;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              ovr_q, ovr_d;

  always_comb begin
    rise   = req_sync_q & ~req_dly_q;
    debt_d = debt_q;
    ovr_d  = ovr_q;
    // A rise and a completion in the same cycle cancel out.
    if (rise && !ref_done_i) begin
      if (debt_q == DEBT_SAT) begin
        ovr_d = 1'b1;
      end else begin
        debt_d = debt_q + 1'b1;
      end
    end else if (!rise && ref_done_i && (debt_q != '0)) begin
      debt_d = debt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_sync_q <= 1'b0;
      req_dly_q  <= 1'b0;
      debt_q     <= '0;
      ovr_q      <= 1'b0;
    end else begin
      req_sync_q <= ref_req_i;
      req_dly_q  <= req_sync_q;
      debt_q     <= debt_d;
      ovr_q      <= ovr_d;
    end
  end

  assign debt_o    = debt_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/iob_arb.sv
// -----------------------------------------------------------------------------
// iob_arb
// Shares the motherboard I/O bus between CPU I/O cycles and DRAM refresh.
// Owed refreshes run opportunistically when the CPU is not requesting, and
// take priority over new CPU grants while RefUrgent is high. A CPU grant is
// never preempted. Every grant and every refresh is followed by REC_CYC idle
// recovery cycles during which all requests are ignored.
//
// Ports:
//   C16M        in   clock, rising edge
//   nRESin      in   asynchronous active-low reset
//   RefReq      in   refresh-due level; each rising edge owes one refresh
//   RefUrgent   in   refresh-overdue level; refresh beats CPU in IDLE
//   IOREQ       in   CPU bus request, held for the whole CPU cycle
//   QoSGate     in   blocks new CPU grants while high
//   IOGNT       out  CPU owns the bus
//   RefACT      out  refresh cycle in progress (REF_CYC cycles)
//   RefStart    out  pulse on the first RefACT cycle
//   RefDebt     out  owed-refresh count
//   RefOverrun  out  sticky refresh-overrun flag
// -----------------------------------------------------------------------------
module iob_arb
  import iob_arb_pkg::*;
#(
  parameter int REF_CYC  = REF_CYC_DEF,
  parameter int REC_CYC  = REC_CYC_DEF,
  parameter int MAX_DEBT = MAX_DEBT_DEF
) (
  input  logic              C16M,
  input  logic              nRESin,
  input  logic              RefReq,
  input  logic              RefUrgent,
  input  logic              IOREQ,
  input  logic              QoSGate,
  output logic              IOGNT,
  output logic              RefACT,
  output logic              RefStart,
  output logic [DEBT_W-1:0] RefDebt,
  output logic              RefOverrun
);

  if ((REF_CYC < REF_CYC_MIN) || (REF_CYC > REF_CYC_MAX) ||
      (REC_CYC < REC_CYC_MIN) || (REC_CYC > REC_CYC_MAX) ||
      (MAX_DEBT < MAX_DEBT_MIN) || (MAX_DEBT > MAX_DEBT_MAX)) begin : g_bad_param
    $error("iob_arb: parameter out of legal range");
  end

  localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(REF_CYC);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(REC_CYC);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              act_q, act_d;
  logic              start_q, start_d;
  logic              owed;
  logic              ref_done;

  iob_arb_ref_debt #(
    .MAX_DEBT (MAX_DEBT)
  ) u_ref_debt (
    .clk_i      (C16M),
    .rst_ni     (nRESin),
    .ref_req_i  (RefReq),
    .ref_done_i (ref_done),
    .debt_o     (RefDebt),
    .overrun_o  (RefOverrun)
  );

  assign owed     = (RefDebt != '0);
  // The cycle counter holds 1 during the final cycle of REF and RECOVER.
  assign ref_done = (state_q == REF) && (cnt_q == CNT_W'(1));

  // State register and registered outputs
  always_ff @(posedge C16M or negedge nRESin) begin
    if (!nRESin) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      act_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      act_q   <= act_d;
      start_q <= start_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (owed && RefUrgent) begin
          state_d = REF;
          cnt_d   = REF_LOAD;
        end else if (IOREQ && !QoSGate) begin
          state_d = GRANT;
        end else if (owed && !IOREQ) begin
          state_d = REF;
          cnt_d   = REF_LOAD;
        end
      end
      GRANT: begin
        if (!IOREQ) begin
          state_d = RECOVER;
          cnt_d   = REC_LOAD;
        end
      end
      REF: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RECOVER;
          cnt_d   = REC_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: outputs are registered copies decoded from the next state
  always_comb begin
    gnt_d   = (state_d == GRANT);
    act_d   = (state_d == REF);
    start_d = (state_d == REF) && (state_q != REF);
  end

  assign IOGNT    = gnt_q;
  assign RefACT   = act_q;
  assign RefStart = start_q;

endmodule

// File: tb/tb_iob_arb.sv
module tb_iob_arb;

  localparam int REF_CYC  = 8;
  localparam int REC_CYC  = 2;
  localparam int MAX_DEBT = 3;

  logic       C16M      = 1'b0;
  logic       nRESin    = 1'b1;
  logic       RefReq    = 1'b0;
  logic       RefUrgent = 1'b0;
  logic       IOREQ     = 1'b0;
  logic       QoSGate   = 1'b0;
  logic       IOGNT;
  logic       RefACT;
  logic       RefStart;
  logic [1:0] RefDebt;
  logic       RefOverrun;

  int checks   = 0;
  int failures = 0;

  iob_arb #(
    .REF_CYC  (REF_CYC),
    .REC_CYC  (REC_CYC),
    .MAX_DEBT (MAX_DEBT)
  ) dut (
    .C16M       (C16M),
    .nRESin     (nRESin),
    .RefReq     (RefReq),
    .RefUrgent  (RefUrgent),
    .IOREQ      (IOREQ),
    .QoSGate    (QoSGate),
    .IOGNT      (IOGNT),
    .RefACT     (RefACT),
    .RefStart   (RefStart),
    .RefDebt    (RefDebt),
    .RefOverrun (RefOverrun)
  );

  always #5 C16M = ~C16M;

  // Behavioural model: bus ownership tracked as "who holds the bus and for how
  // many more cycles", debt as a plain integer fed by a two-deep RefReq history.
  bit m_h1, m_h2;
  int m_debt;
  bit m_ovr;
  bit m_gnt;
  int m_ref_left;
  int m_rec_left;
  bit m_first;

  always @(posedge C16M or negedge nRESin) begin : model
    bit rise, done, n_gnt, n_first, n_ovr;
    int n_ref, n_rec, n_debt;
    if (!nRESin) begin
      m_h1 <= 1'b0; m_h2 <= 1'b0; m_debt <= 0; m_ovr <= 1'b0;
      m_gnt <= 1'b0; m_ref_left <= 0; m_rec_left <= 0; m_first <= 1'b0;
    end else begin
      rise    = m_h1 && !m_h2;
      done    = (m_ref_left == 1);
      n_gnt   = m_gnt;
      n_ref   = m_ref_left;
      n_rec   = m_rec_left;
      n_first = 1'b0;
      n_debt  = m_debt;
      n_ovr   = m_ovr;
      if (m_gnt) begin
        if (!IOREQ) begin n_gnt = 1'b0; n_rec = REC_CYC; end
      end else if (m_ref_left > 0) begin
        n_ref = m_ref_left - 1;
        if (n_ref == 0) n_rec = REC_CYC;
      end else if (m_rec_left > 0) begin
        n_rec = m_rec_left - 1;
      end else if (m_debt > 0 && RefUrgent) begin
        n_ref = REF_CYC; n_first = 1'b1;
      end else if (IOREQ && !QoSGate) begin
        n_gnt = 1'b1;
      end else if (m_debt > 0 && !IOREQ) begin
        n_ref = REF_CYC; n_first = 1'b1;
      end
      if (rise && !done) begin
        if (m_debt == MAX_DEBT) n_ovr = 1'b1;
        else n_debt = m_debt + 1;
      end else if (done && !rise && m_debt > 0) begin
        n_debt = m_debt - 1;
      end
      m_gnt <= n_gnt; m_ref_left <= n_ref; m_rec_left <= n_rec; m_first <= n_first;
      m_debt <= n_debt; m_ovr <= n_ovr;
      m_h2 <= m_h1; m_h1 <= RefReq;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge C16M);
    #2;
  endtask

  task automatic stim();
    int act, st, seen, n, g;
    // Reset state
    #1 nRESin = 1'b0;
    tick(); tick();
    check("rst_IOGNT", 32'(IOGNT), 0);
    check("rst_RefACT", 32'(RefACT), 0);
    check("rst_RefDebt", 32'(RefDebt), 0);
    check("rst_RefOverrun", 32'(RefOverrun), 0);
    nRESin = 1'b1;
    tick();

    // Single opportunistic refresh
    RefReq = 1'b1; tick(); RefReq = 1'b0;
    act = 0; st = 0; seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      act += int'(RefACT); st += int'(RefStart);
      if (RefDebt == 2'd1) seen = 1;
    end
    check("t1_act_cycles", act, 8);
    check("t1_start_pulses", st, 1);
    check("t1_debt_seen_1", seen, 1);
    check("t1_debt_end", 32'(RefDebt), 0);

    // CPU grant while a refresh is owed but not urgent
    RefReq = 1'b1; IOREQ = 1'b1; tick();
    check("t2_gnt_latency", 32'(IOGNT), 1);
    RefReq = 1'b0;
    act = 0;
    for (int i = 0; i < 5; i++) begin tick(); act += int'(RefACT); end
    check("t2_no_ref_in_grant", act, 0);
    check("t2_debt", 32'(RefDebt), 1);
    IOREQ = 1'b0; n = 0;
    do begin tick(); n++; end while (!RefACT && n < 20);
    check("t2_ref_after_rec", n, 4);
    for (int i = 0; i < 12; i++) tick();

    // Urgent refresh wins over a simultaneous CPU request
    IOREQ = 1'b1; tick();
    RefReq = 1'b1; tick(); RefReq = 1'b0; tick(); tick();
    check("t3_debt", 32'(RefDebt), 1);
    IOREQ = 1'b0; RefUrgent = 1'b1; tick();
    IOREQ = 1'b1; n = 0;
    do begin tick(); n++; end while (!RefACT && n < 10);
    check("t3_ref_first", 32'(RefACT), 1);
    check("t3_no_gnt_during_ref", 32'(IOGNT), 0);
    n = 0;
    do begin tick(); n++; end while (!IOGNT && n < 30);
    check("t3_gnt_after_ref", n, 11);
    RefUrgent = 1'b0; IOREQ = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // QoSGate holds off the CPU
    QoSGate = 1'b1; IOREQ = 1'b1; g = 0;
    for (int i = 0; i < 20; i++) begin tick(); g += int'(IOGNT); end
    check("t4_qos_block", g, 0);
    QoSGate = 1'b0; tick();
    check("t4_gnt_after_qos", 32'(IOGNT), 1);
    IOREQ = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Debt saturation and overrun while the CPU holds the bus
    IOREQ = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin RefReq = 1'b1; tick(); RefReq = 1'b0; tick(); end
    tick(); tick();
    check("t5_debt_sat", 32'(RefDebt), 3);
    check("t5_overrun", 32'(RefOverrun), 1);
    check("t5_still_granted", 32'(IOGNT), 1);
    IOREQ = 1'b0; act = 0; st = 0;
    for (int i = 0; i < 50; i++) begin
      tick(); act += int'(RefACT); st += int'(RefStart);
    end
    check("t5_three_refreshes", st, 3);
    check("t5_act_cycles", act, 24);
    check("t5_debt_end", 32'(RefDebt), 0);
    check("t5_overrun_sticky", 32'(RefOverrun), 1);

    // Asynchronous reset in the middle of a refresh
    RefReq = 1'b1; tick(); RefReq = 1'b0; n = 0;
    do begin tick(); n++; end while (!RefACT && n < 10);
    tick(); tick(); tick();
    check("t6_in_ref", 32'(RefACT), 1);
    check("t6_debt_pre", 32'(RefDebt), 1);
    nRESin = 1'b0; #1;
    check("t6_rst_IOGNT", 32'(IOGNT), 0);
    check("t6_rst_RefACT", 32'(RefACT), 0);
    check("t6_rst_RefStart", 32'(RefStart), 0);
    check("t6_rst_RefDebt", 32'(RefDebt), 0);
    check("t6_rst_RefOverrun", 32'(RefOverrun), 0);
    tick(); tick();
    nRESin = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t6_idle_act", 32'(RefACT), 0);
    check("t6_idle_gnt", 32'(IOGNT), 0);
  endtask

  initial begin
    fork
      begin : compare
        forever begin
          @(negedge C16M);
          check("IOGNT", 32'(IOGNT), 32'(m_gnt));
          check("RefACT", 32'(RefACT), 32'(m_ref_left > 0));
          check("RefStart", 32'(RefStart), 32'(m_first));
          check("RefDebt", 32'(RefDebt), 32'(m_debt));
          check("RefOverrun", 32'(RefOverrun), 32'(m_ovr));
        end
      end
      stim();
      begin : watchdog
        #50000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
